// File: rtl/btn_evt_pkg.sv
// -----------------------------------------------------------------------------
// btn_evt_pkg
// Shared definitions for the front-panel button event encoder.
//   EVT_ON / EVT_OFF / EVT_ERR / EVT_OPEN : 2-bit button codes (also the bit
//                                           index of each button in the
//                                           NUM_BTN-wide vectors)
//   EVT_ENTRY_W                           : width of one queued event
//   NUM_BTN                               : number of front-panel buttons
//   evt_entry_t                           : queued event {long_press, code}
//   pick_t / pick_btn()                   : fixed-priority pending-flag picker
// -----------------------------------------------------------------------------
package btn_evt_pkg;

   localparam logic [1:0] EVT_ON   = 2'd0;
   localparam logic [1:0] EVT_OFF  = 2'd1;
   localparam logic [1:0] EVT_ERR  = 2'd2;
   localparam logic [1:0] EVT_OPEN = 2'd3;

   localparam int EVT_ENTRY_W = 3;
   localparam int NUM_BTN     = 4;

   typedef struct packed {
      logic       long_press;
      logic [1:0] code;
   } evt_entry_t;

   typedef struct packed {
      logic       hit;
      logic [1:0] idx;
   } pick_t;

   // Picks one requesting button. Order is ERR > OFF > ON > OPEN, which is
   // not the numeric order of the codes, hence the explicit chain.
   function automatic pick_t pick_btn(input logic [NUM_BTN-1:0] req);
      pick_t p;
      p.hit = 1'b1;
      p.idx = EVT_ON;
      if (req[EVT_ERR])       p.idx = EVT_ERR;
      else if (req[EVT_OFF])  p.idx = EVT_OFF;
      else if (req[EVT_ON])   p.idx = EVT_ON;
      else if (req[EVT_OPEN]) p.idx = EVT_OPEN;
      else                    p.hit = 1'b0;
      return p;
   endfunction

endpackage

// File: rtl/evt_fifo.sv
// -----------------------------------------------------------------------------
// evt_fifo
// Synchronous first-word-fall-through FIFO. The head entry is visible on
// pop_data_o whenever empty_o is low; a pop simply advances past it.
//   W, DEPTH    : entry width, entry count (power of two, >= 2)
//   clk_i       : clock, rising edge
//   rst_i       : synchronous active-high reset (empties the queue)
//   push_i      : write push_data_i; ignored while full_o is high
//   push_data_i : entry to write
//   pop_i       : drop the head entry; ignored while empty_o is high
//   pop_data_o  : head entry (meaningful only while empty_o is low)
//   full_o      : occupancy == DEPTH
//   empty_o     : occupancy == 0
// A push while full is refused even if a pop happens in the same cycle.
// -----------------------------------------------------------------------------
module evt_fifo #(
   parameter int W     = 3,
   parameter int DEPTH = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push_i,
   input  logic [W-1:0] push_data_i,
   input  logic         pop_i,
   output logic [W-1:0] pop_data_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full_o     = (cnt_q == FULL_CNT);
   assign empty_o    = (cnt_q == '0);
   assign do_push    = push_i & ~full_o;
   assign do_pop     = pop_i & ~empty_o;
   assign pop_data_o = mem_q[rd_ptr_q];

   // Pointers are AW bits wide and DEPTH is a power of two, so the
   // increment wraps modulo DEPTH on its own.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: an entry is only ever read after being written.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/button_event_encoder.sv
// -----------------------------------------------------------------------------
// button_event_encoder
// Turns the four debounced front-panel levels into queued press events.
// Rising edges set per-button short-pending flags; a fixed-priority arbiter
// moves at most one flag per cycle into an event FIFO read over valid/ready.
// Optional long-press detection is compiled in with `define BTN_LONG_PRESS_EN.
//
// Parameters
//   HOLD_CYCLES : high cycles (edge cycle included) for a long press, >= 2
//   FIFO_DEPTH  : event queue depth, power of two, >= 2
// Ports
//   clk_50MHz   : clock, rising edge
//   reset       : synchronous active-high reset
//   btn_on, btn_off, btn_err, btn_open : debounced levels, 1 = pressed
//   evt_valid   : queue head holds an event
//   evt_ready   : consumer accepts the head event
//   evt_code    : head button code (0 ON, 1 OFF, 2 ERR, 3 OPEN)
//   evt_long    : head event is a long press
//   overflow    : sticky, an event was dropped; cleared only by reset
//
// Event handshake: an event transfers on every rising edge where
// evt_valid & evt_ready; while evt_valid is high and evt_ready low the head
// (evt_code/evt_long) holds steady; evt_valid never depends on evt_ready.
// -----------------------------------------------------------------------------
module button_event_encoder
   import btn_evt_pkg::*;
#(
   parameter int HOLD_CYCLES = 50_000_000,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic       clk_50MHz,
   input  logic       reset,
   input  logic       btn_on,
   input  logic       btn_off,
   input  logic       btn_err,
   input  logic       btn_open,
   output logic       evt_valid,
   input  logic       evt_ready,
   output logic [1:0] evt_code,
   output logic       evt_long,
   output logic       overflow
);

   if (HOLD_CYCLES < 2) begin : g_bad_hold
      $error("HOLD_CYCLES must be at least 2");
   end
   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two and at least 2");
   end

   // Bit index of each button equals its event code.
   logic [NUM_BTN-1:0] btn;
   logic [NUM_BTN-1:0] prev_q;
   logic [NUM_BTN-1:0] rise;
   logic [NUM_BTN-1:0] spend_q, spend_d, spend_keep, spend_clr;
   logic [NUM_BTN-1:0] lpend_q;
   logic [NUM_BTN-1:0] push_sel;
   logic               short_drop, long_drop;
   logic               ovf_q, ovf_d;

   pick_t      spick, lpick;
   logic       push;
   evt_entry_t push_entry, head_entry;
   logic       fifo_full, fifo_empty;

   assign btn  = {btn_open, btn_err, btn_off, btn_on};
   assign rise = btn & ~prev_q;

   // ---------------------------------------------------------------------------
   // Arbiter: every short flag beats every long flag. Nothing moves while the
   // FIFO is full, so flags simply wait there.
   // ---------------------------------------------------------------------------
   always_comb begin
      spick      = pick_btn(spend_q);
      lpick      = pick_btn(lpend_q);
      push       = 1'b0;
      push_entry = '0;
      if (!fifo_full) begin
         if (spick.hit) begin
            push                  = 1'b1;
            push_entry.long_press = 1'b0;
            push_entry.code       = spick.idx;
         end else if (lpick.hit) begin
            push                  = 1'b1;
            push_entry.long_press = 1'b1;
            push_entry.code       = lpick.idx;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Short-pending flags. The flag being pushed this cycle is cleared before
   // the new edge is applied, so an edge arriving exactly as its previous
   // event leaves for the FIFO re-arms the flag instead of being dropped.
   // ---------------------------------------------------------------------------
   always_comb begin
      push_sel = '0;
      if (push) push_sel[push_entry.code] = 1'b1;
      spend_clr  = push_sel & {NUM_BTN{~push_entry.long_press}};
      spend_keep = spend_q & ~spend_clr;
      spend_d    = spend_keep | rise;
      short_drop = |(rise & spend_keep);
   end

   assign ovf_d = ovf_q | short_drop | long_drop;

   // prev resets high so a button held through reset is not reported.
   always_ff @(posedge clk_50MHz) begin
      if (reset) begin
         prev_q  <= '1;
         spend_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         prev_q  <= btn;
         spend_q <= spend_d;
         ovf_q   <= ovf_d;
      end
   end

`ifdef BTN_LONG_PRESS_EN
   // ---------------------------------------------------------------------------
   // Long-press detection. A rising edge arms the button and loads the counter
   // with 1 (the edge cycle is the first high cycle). Each further high cycle
   // while armed counts up; the high cycle seen with the counter at
   // HOLD_CYCLES-1 is the HOLD_CYCLES-th one, which raises lpend and disarms.
   // Disarming parks the counter at 0, so it never reaches past HOLD_CYCLES-1.
   // ---------------------------------------------------------------------------
   localparam int HOLD_W = $clog2(HOLD_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   logic [NUM_BTN-1:0][HOLD_W-1:0] hold_q, hold_d;
   logic [NUM_BTN-1:0]             armed_q, armed_d;
   logic [NUM_BTN-1:0]             lfire;
   logic [NUM_BTN-1:0]             lpend_d, lpend_keep, lpend_clr;

   always_comb begin
      for (int i = 0; i < NUM_BTN; i++) begin
         hold_d[i]  = '0;
         armed_d[i] = 1'b0;
         lfire[i]   = 1'b0;
         if (btn[i]) begin
            if (rise[i]) begin
               armed_d[i] = 1'b1;
               hold_d[i]  = HOLD_W'(1);
            end else if (armed_q[i]) begin
               if (hold_q[i] == HOLD_LAST) begin
                  lfire[i] = 1'b1;
               end else begin
                  armed_d[i] = 1'b1;
                  hold_d[i]  = hold_q[i] + HOLD_W'(1);
               end
            end
         end
      end
   end

   always_comb begin
      lpend_clr  = push_sel & {NUM_BTN{push_entry.long_press}};
      lpend_keep = lpend_q & ~lpend_clr;
      lpend_d    = lpend_keep | lfire;
      long_drop  = |(lfire & lpend_keep);
   end

   always_ff @(posedge clk_50MHz) begin
      if (reset) begin
         hold_q  <= '0;
         armed_q <= '0;
         lpend_q <= '0;
      end else begin
         hold_q  <= hold_d;
         armed_q <= armed_d;
         lpend_q <= lpend_d;
      end
   end
`else
   // Long presses are not built: no long flag can ever be raised.
   assign lpend_q   = '0;
   assign long_drop = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Event queue
   // ---------------------------------------------------------------------------
   evt_fifo #(
      .W     (EVT_ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i       (clk_50MHz),
      .rst_i       (reset),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (evt_ready),
      .pop_data_o  (head_entry),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   // Head fields read as 0 while the queue is empty. Without long-press
   // support every pushed entry carries long_press = 0, so evt_long stays 0.
   assign evt_valid = ~fifo_empty;
   assign evt_code  = fifo_empty ? EVT_ON : head_entry.code;
   assign evt_long  = ~fifo_empty & head_entry.long_press;
   assign overflow  = ovf_q;

endmodule
